// File: rtl/apb_slave_regfile.sv
// APB3 completer holding RW_REGS read/write control registers followed by
// read-only status words. Each transfer has a fixed number of wait states.
// Bad accesses answer with slverr and are counted in a saturating counter.
`timescale 1ns/1ps
module apb_slave_regfile #(
  parameter int DBITS    = 16,
  parameter int ABITS    = 10,
  parameter int NREGS    = 8,
  parameter int RW_REGS  = 6,
  parameter int WAIT_CYC = 1
) (
  input  logic                             apb_clk,
  input  logic                             apb_rst,
  input  logic                             apb_sel,
  input  logic                             apb_enable,
  input  logic                             apb_write,
  input  logic [ABITS-1:0]                 apb_addr,
  input  logic [DBITS-1:0]                 apb_wdata,
  output logic [DBITS-1:0]                 apb_rdata,
  output logic                             apb_ready,
  output logic                             apb_slverr,
  input  logic [(NREGS-RW_REGS)*DBITS-1:0] sts_in,
  output logic [RW_REGS*DBITS-1:0]         reg_q,
  output logic                             wr_stb,
  output logic [ABITS-1:0]                 wr_idx,
  output logic [15:0]                      err_cnt
);

  localparam int RW_N    = (RW_REGS > 0) ? RW_REGS : 1;
  localparam int RO_REGS = NREGS - RW_REGS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ABITS-1:0]  addr_q;
  logic              write_q;
  logic [DBITS-1:0]  wdata_q;
  logic [DBITS-1:0]  regs [RW_N];

  logic              setup, complete, enter_done, commit_rw;
  logic [ABITS-1:0]  dec_addr;
  logic              dec_write;
  logic [31:0]       dec_idx, addr_idx;
  logic              resp_err;
  logic [DBITS-1:0]  resp_data;

  assign setup      = apb_sel & ~apb_enable;
  assign complete   = (state == S_DONE) & apb_sel & apb_enable;
  assign enter_done = (state_nxt == S_DONE) & (state != S_DONE);

  // In IDLE the response is decoded from the live bus (zero-wait case),
  // afterwards from the copy captured at setup.
  assign dec_addr  = (state == S_IDLE) ? apb_addr  : addr_q;
  assign dec_write = (state == S_IDLE) ? apb_write : write_q;
  assign dec_idx   = 32'(dec_addr);
  assign addr_idx  = 32'(addr_q);
  assign commit_rw = complete & write_q & (addr_idx < RW_REGS);

  // State register
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; an early sel drop aborts back to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (setup) state_nxt = (WAIT_CYC == 0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (!apb_sel)        state_nxt = S_IDLE;
        else if (cnt == 4'd1) state_nxt = S_DONE;
      end
      S_DONE: if (!apb_sel || apb_enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response decode: register, status word, or error with zero data
  always_comb begin
    resp_err  = (dec_idx >= NREGS) || (dec_write && (dec_idx >= RW_REGS));
    resp_data = '0;
    if (!dec_write) begin
      for (int i = 0; i < RW_REGS; i++)
        if (dec_idx == i) resp_data = regs[i];
      for (int j = 0; j < RO_REGS; j++)
        if (dec_idx == RW_REGS + j) resp_data = sts_in[j*DBITS +: DBITS];
    end
  end

  // Wait-state counter and transfer direction captured at setup
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      cnt     <= '0;
      write_q <= 1'b0;
    end else if (state == S_IDLE && setup) begin
      cnt     <= 4'(WAIT_CYC);
      write_q <= apb_write;
    end else if (state == S_WAIT) begin
      cnt <= apb_sel ? cnt - 4'd1 : 4'd0;
    end
  end

  // Address and write data held for the whole access phase
  always_ff @(posedge apb_clk) begin
    if (state == S_IDLE && setup) begin
      addr_q  <= apb_addr;
      wdata_q <= apb_wdata;
    end
  end

  // Registered response, set on DONE entry and cleared on leaving DONE
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      apb_ready  <= 1'b0;
      apb_slverr <= 1'b0;
      apb_rdata  <= '0;
    end else if (enter_done) begin
      apb_ready  <= 1'b1;
      apb_slverr <= resp_err;
      apb_rdata  <= resp_err ? '0 : resp_data;
    end else if (state == S_DONE && state_nxt != S_DONE) begin
      apb_ready  <= 1'b0;
      apb_slverr <= 1'b0;
      apb_rdata  <= '0;
    end
  end

  // Control register file, written only when a legal write completes
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      for (int i = 0; i < RW_N; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < RW_REGS; i++)
        if (commit_rw && addr_idx == i) regs[i] <= wdata_q;
    end
  end

  // One-cycle commit strobe with the written index
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      wr_stb <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_stb <= commit_rw;
      if (commit_rw) wr_idx <= addr_q;
    end
  end

  // Saturating count of completed error responses
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      err_cnt <= '0;
    end else if (complete && apb_slverr && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  // Flatten the register file onto the reg_q bus, register 0 in the LSBs
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < RW_REGS; i++) reg_q[i*DBITS +: DBITS] = regs[i];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with 1, 0 and 3 wait states,
// a table of directed vectors, hand-written corner sequences and random
// transfers scored against an array-based model of the register map.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel [3];
  logic        en [3];
  logic        wr [3];
  logic [9:0]  addr [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ready [3];
  logic        slverr [3];
  logic [31:0] sts [3];
  logic [95:0] regq [3];
  logic        wr_stb [3];
  logic [9:0]  wr_idx [3];
  logic [15:0] err_cnt [3];
  int          wait_cyc [3] = '{1, 0, 3};

  apb_slave_regfile #(.DBITS(16), .ABITS(10), .NREGS(8), .RW_REGS(6), .WAIT_CYC(1)) u0 (
    .apb_clk(clk), .apb_rst(rst), .apb_sel(sel[0]), .apb_enable(en[0]), .apb_write(wr[0]),
    .apb_addr(addr[0]), .apb_wdata(wdata[0]), .apb_rdata(rdata[0]), .apb_ready(ready[0]),
    .apb_slverr(slverr[0]), .sts_in(sts[0]), .reg_q(regq[0]), .wr_stb(wr_stb[0]),
    .wr_idx(wr_idx[0]), .err_cnt(err_cnt[0]));

  apb_slave_regfile #(.DBITS(16), .ABITS(10), .NREGS(8), .RW_REGS(6), .WAIT_CYC(0)) u1 (
    .apb_clk(clk), .apb_rst(rst), .apb_sel(sel[1]), .apb_enable(en[1]), .apb_write(wr[1]),
    .apb_addr(addr[1]), .apb_wdata(wdata[1]), .apb_rdata(rdata[1]), .apb_ready(ready[1]),
    .apb_slverr(slverr[1]), .sts_in(sts[1]), .reg_q(regq[1]), .wr_stb(wr_stb[1]),
    .wr_idx(wr_idx[1]), .err_cnt(err_cnt[1]));

  apb_slave_regfile #(.DBITS(16), .ABITS(10), .NREGS(8), .RW_REGS(6), .WAIT_CYC(3)) u2 (
    .apb_clk(clk), .apb_rst(rst), .apb_sel(sel[2]), .apb_enable(en[2]), .apb_write(wr[2]),
    .apb_addr(addr[2]), .apb_wdata(wdata[2]), .apb_rdata(rdata[2]), .apb_ready(ready[2]),
    .apb_slverr(slverr[2]), .sts_in(sts[2]), .reg_q(regq[2]), .wr_stb(wr_stb[2]),
    .wr_idx(wr_idx[2]), .err_cnt(err_cnt[2]));

  int checks = 0;
  int failures = 0;

  // Reference model: register contents and error count per instance
  logic [15:0] m_regs [3][6];
  int          m_err [3];

  typedef struct {
    bit          w;
    logic [9:0]  a;
    logic [15:0] wd;
    logic [31:0] s;
    logic [15:0] rd;
    logic        err;
    logic        stb;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_err[d] = 0;
      for (int i = 0; i < 6; i++) m_regs[d][i] = '0;
    end
  endtask

  task automatic model_xfer(input int d, input bit w, input int a, input logic [15:0] wd,
                            input logic [31:0] s, output logic [15:0] rd,
                            output logic err, output logic stb);
    err = (a >= 8) || (w && a >= 6);
    rd  = '0;
    stb = 1'b0;
    if (!err) begin
      if (w) begin
        m_regs[d][a] = wd;
        stb = 1'b1;
      end else if (a < 6) begin
        rd = m_regs[d][a];
      end else begin
        rd = s[(a-6)*16 +: 16];
      end
    end
    if (err && m_err[d] < 65535) m_err[d]++;
  endtask

  function automatic logic [95:0] model_q(input int d);
    logic [95:0] q;
    for (int i = 0; i < 6; i++) q[i*16 +: 16] = m_regs[d][i];
    return q;
  endfunction

  // One APB transfer starting at a negedge; ends one negedge after completion
  task automatic xfer(input int d, input bit w, input logic [9:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic err, output int cyc,
                      output logic stb, output logic [9:0] sidx, output logic rdy_after);
    sel[d] = 1'b1; en[d] = 1'b0; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    en[d] = 1'b1;
    addr[d]  = 10'($urandom);
    wdata[d] = 16'($urandom);
    cyc = 1;
    while (ready[d] !== 1'b1 && cyc <= 20) begin
      @(negedge clk);
      cyc++;
    end
    rd  = rdata[d];
    err = slverr[d];
    @(negedge clk);
    stb = wr_stb[d];
    sidx = wr_idx[d];
    rdy_after = ready[d];
    sel[d] = 1'b0; en[d] = 1'b0;
  endtask

  task automatic run_check(input int d, input bit w, input int a, input logic [15:0] wd,
                           input string tag);
    logic [15:0] erd, rd;
    logic eerr, err, estb, stb, rdy;
    logic [9:0] sidx;
    int cyc;
    model_xfer(d, w, a, wd, sts[d], erd, eerr, estb);
    xfer(d, w, 10'(a), wd, rd, err, cyc, stb, sidx, rdy);
    if (!w) chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_slverr"}, err, eerr);
    chk({tag, "_cycles"}, cyc, wait_cyc[d] + 1);
    chk({tag, "_wr_stb"}, stb, estb);
    if (estb) chk({tag, "_wr_idx"}, sidx, 10'(a));
    chk({tag, "_ready_after"}, rdy, 1'b0);
    chk({tag, "_reg_q"}, regq[d], model_q(d));
    chk({tag, "_err_cnt"}, err_cnt[d], m_err[d]);
  endtask

  task automatic check_reset(input int d, input string tag);
    chk({tag, "_ready"}, ready[d], 1'b0);
    chk({tag, "_slverr"}, slverr[d], 1'b0);
    chk({tag, "_rdata"}, rdata[d], 16'h0);
    chk({tag, "_reg_q"}, regq[d], 96'h0);
    chk({tag, "_wr_stb"}, wr_stb[d], 1'b0);
    chk({tag, "_wr_idx"}, wr_idx[d], 10'h0);
    chk({tag, "_err_cnt"}, err_cnt[d], 16'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] t_rd, d_rd;
  logic        t_err, t_stb, t_rdy, d_err, d_stb, seen;
  logic [9:0]  t_idx;
  int          t_cyc, ra;

  initial begin
    tbl[0] = '{w:1'b1, a:10'd2, wd:16'hA5C3, s:32'h0,         rd:16'h0,    err:1'b0, stb:1'b1};
    tbl[1] = '{w:1'b0, a:10'd2, wd:16'h0,    s:32'h0,         rd:16'hA5C3, err:1'b0, stb:1'b0};
    tbl[2] = '{w:1'b0, a:10'd6, wd:16'h0,    s:32'h0000_1234, rd:16'h1234, err:1'b0, stb:1'b0};
    tbl[3] = '{w:1'b1, a:10'd7, wd:16'hBEEF, s:32'h0000_1234, rd:16'h0,    err:1'b1, stb:1'b0};
    tbl[4] = '{w:1'b0, a:10'd9, wd:16'h0,    s:32'h0000_1234, rd:16'h0,    err:1'b1, stb:1'b0};
    tbl[5] = '{w:1'b0, a:10'd7, wd:16'h0,    s:32'h5678_1234, rd:16'h5678, err:1'b0, stb:1'b0};
    tbl[6] = '{w:1'b1, a:10'd5, wd:16'hFFFF, s:32'h5678_1234, rd:16'h0,    err:1'b0, stb:1'b1};
    tbl[7] = '{w:1'b0, a:10'd5, wd:16'h0,    s:32'h5678_1234, rd:16'hFFFF, err:1'b0, stb:1'b0};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sel[d] = 1'b0; en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; sts[d] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset(0, "rst0");
    check_reset(1, "rst1");
    check_reset(2, "rst2");
    rst = 1'b0;
    @(negedge clk);

    // Directed table on the one-wait-state instance
    for (int i = 0; i < 8; i++) begin
      sts[0] = tbl[i].s;
      model_xfer(0, tbl[i].w, int'(tbl[i].a), tbl[i].wd, tbl[i].s, d_rd, d_err, d_stb);
      xfer(0, tbl[i].w, tbl[i].a, tbl[i].wd, t_rd, t_err, t_cyc, t_stb, t_idx, t_rdy);
      if (!tbl[i].w) chk($sformatf("tbl%0d_rdata", i), t_rd, tbl[i].rd);
      chk($sformatf("tbl%0d_slverr", i), t_err, tbl[i].err);
      chk($sformatf("tbl%0d_wr_stb", i), t_stb, tbl[i].stb);
      if (tbl[i].stb) chk($sformatf("tbl%0d_wr_idx", i), t_idx, tbl[i].a);
      chk($sformatf("tbl%0d_cycles", i), t_cyc, 2);
      chk($sformatf("tbl%0d_ready_after", i), t_rdy, 1'b0);
    end
    chk("tbl_reg_q_idx2", regq[0][47:32], 16'hA5C3);
    chk("tbl_reg_q_all", regq[0], {16'hFFFF, 16'h0, 16'h0, 16'hA5C3, 16'h0, 16'h0});
    chk("tbl_err_cnt", err_cnt[0], 16'd2);

    // Zero wait states, back-to-back writes
    run_check(1, 1'b1, 0, 16'h1111, "b2b_w0");
    run_check(1, 1'b1, 1, 16'h2222, "b2b_w1");
    chk("b2b_reg_q", regq[1][31:0], 32'h2222_1111);

    // Three wait states, sel dropped in the second wait cycle
    sel[2] = 1'b1; en[2] = 1'b0; wr[2] = 1'b1; addr[2] = 10'd3; wdata[2] = 16'h7777;
    @(negedge clk);
    en[2] = 1'b1;
    @(negedge clk);
    sel[2] = 1'b0; en[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready[2] !== 1'b0 || wr_stb[2] !== 1'b0) seen = 1'b1;
    end
    chk("abort_ready_or_stb", seen, 1'b0);
    chk("abort_reg_q", regq[2], 96'h0);
    chk("abort_err_cnt", err_cnt[2], 16'h0);
    run_check(2, 1'b1, 3, 16'h8888, "abort_next_w");

    // Saturation of the error counter
    force u1.err_cnt = 16'hFFFF;
    @(negedge clk);
    release u1.err_cnt;
    m_err[1] = 65535;
    chk("sat_preset", err_cnt[1], 16'hFFFF);
    run_check(1, 1'b0, 9, 16'h0, "sat_err");

    // Asynchronous reset in the middle of a waited write
    run_check(2, 1'b0, 10, 16'h0, "pre_rst_err");
    sel[2] = 1'b1; en[2] = 1'b0; wr[2] = 1'b1; addr[2] = 10'd4; wdata[2] = 16'hCAFE;
    @(negedge clk);
    en[2] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset(2, "async_rst");
    chk("async_rst_reg_q0", regq[0], 96'h0);
    @(negedge clk);
    sel[2] = 1'b0; en[2] = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("async_rst_no_write", regq[2], 96'h0);
    chk("async_rst_no_stb", wr_stb[2], 1'b0);

    // Random transfers on all three instances
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 11));
        sts[d] = $urandom;
        run_check(d, 1'($urandom_range(0, 1)), ra, 16'($urandom), $sformatf("rnd%0d_%0d", d, n));
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
